// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Common-data-bus arbiter for an out-of-order core. Buffers ALU
//             and memory-unit results in two small FIFOs and broadcasts one
//             result per cycle on a registered CDB. When both sources have
//             work, a priority pointer alternates between them.
//  Ports    : clk, rst (sync, active-low), flush (sync, active-high)
//             alu_valid/alu_tag/alu_data -> alu_ready   : ALU result input
//             mem_valid/mem_tag/mem_data -> mem_ready   : memory result input
//             cdb_stall                                  : consumer backpressure
//             cdb_valid/cdb_tag/cdb_data                 : registered broadcast
//             conflict_cnt                               : saturating contention count
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [TAG_W-1:0]  mem_tag,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              cdb_stall,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [15:0]       conflict_cnt
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

    // Source index 0 is the ALU, index 1 is the memory unit.
    logic [1:0]        in_valid;
    logic [TAG_W-1:0]  in_tag    [2];
    logic [DATA_W-1:0] in_data   [2];
    logic [1:0]        not_full;
    logic [1:0]        not_empty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [TAG_W-1:0]  head_tag  [2];
    logic [DATA_W-1:0] head_data [2];

    // High means the memory unit wins the next contended grant.
    logic prio_mem;
    logic grant_en;
    logic both_ne;
    logic grant_alu;
    logic grant_mem;

    assign in_valid   = {mem_valid, alu_valid};
    assign in_tag[0]  = alu_tag;
    assign in_tag[1]  = mem_tag;
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;

    // Ready depends only on the current occupancy, never on a same-cycle pop,
    // so a full FIFO refuses input even while it is being drained.
    assign alu_ready = rst && not_full[0];
    assign mem_ready = rst && not_full[1];

    assign grant_en  = rst && !flush && !cdb_stall;
    assign both_ne   = &not_empty;
    assign grant_alu = grant_en && not_empty[0] && (!not_empty[1] || !prio_mem);
    assign grant_mem = grant_en && not_empty[1] && (!not_empty[0] ||  prio_mem);
    assign pop       = {grant_mem, grant_alu};

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [TAG_W-1:0]  tag_mem  [DEPTH];
        logic [DATA_W-1:0] data_mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;

        assign not_full[s]  = (count != FULL_CNT);
        assign not_empty[s] = (count != '0);
        // Tag 0 means "no result", so such offers are accepted and discarded.
        assign push[s]      = rst && !flush && in_valid[s] && not_full[s]
                              && (in_tag[s] != '0);
        assign head_tag[s]  = tag_mem[rd_ptr];
        assign head_data[s] = data_mem[rd_ptr];

        // Storage needs no reset: occupancy alone decides what is live.
        always_ff @(posedge clk) begin
            if (push[s]) begin
                tag_mem[wr_ptr]  <= in_tag[s];
                data_mem[wr_ptr] <= in_data[s];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst || flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[s]) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop[s]) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                count <= count + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            prio_mem     <= 1'b1;
            conflict_cnt <= '0;
        end else if (flush) begin
            // Contention history survives a flush; only in-flight work dies.
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            prio_mem  <= 1'b1;
        end else if (!cdb_stall) begin
            if (grant_alu) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= head_tag[0];
                cdb_data  <= head_data[0];
            end else if (grant_mem) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= head_tag[1];
                cdb_data  <= head_data[1];
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
                cdb_data  <= '0;
            end
            // The pointer only moves when there was a real choice to make.
            if (both_ne) begin
                prio_mem <= ~prio_mem;
                if (conflict_cnt != CNT_MAX) begin
                    conflict_cnt <= conflict_cnt + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter. Expected broadcasts are
//             queued as stimulus is applied; a negedge monitor pops and
//             compares every broadcast the consumer accepts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [TAG_W-1:0]  mem_tag;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              cdb_stall;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [15:0]       conflict_cnt;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } res_t;

    res_t exp_q[$];
    int   n_cmp        = 0;
    int   n_err        = 0;
    int   exp_conflict = 0;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alu_valid    (alu_valid),
        .alu_tag      (alu_tag),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_tag      (mem_tag),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .cdb_stall    (cdb_stall),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // A broadcast is consumed at the coming posedge when the bus is valid and
    // the consumer is not stalling; that is when the scoreboard pops.
    always @(negedge clk) begin
        res_t e;
        if (rst === 1'b1 && flush === 1'b0 && cdb_stall === 1'b0 && cdb_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_broadcast: got tag %0d data %h, required no broadcast",
                         cdb_tag, cdb_data);
            end else begin
                e = exp_q.pop_front();
                if (cdb_tag !== e.tag || cdb_data !== e.data) begin
                    n_err++;
                    $display("FAIL broadcast_order: got tag %0d data %h, required tag %0d data %h",
                             cdb_tag, cdb_data, e.tag, e.data);
                end
            end
        end
        if (cdb_valid === 1'b0) begin
            n_cmp++;
            if (cdb_tag !== '0 || cdb_data !== '0) begin
                n_err++;
                $display("FAIL idle_zero: got tag %0d data %h, required tag 0 data 0",
                         cdb_tag, cdb_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_tag = '0; alu_data = '0;
        mem_valid = 1'b0; mem_tag = '0; mem_data = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d results still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        // Give any stray extra broadcast a chance to reach the monitor.
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; cdb_stall = 1'b0;
        idle_inputs();
        repeat (3) step();
        n_cmp++;
        if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0) begin
            n_err++;
            $display("FAIL reset_cdb: got v=%b t=%0d d=%h, required 0/0/0", cdb_valid, cdb_tag, cdb_data);
        end
        n_cmp++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got alu=%b mem=%b, required 0/0", alu_ready, mem_ready);
        end
        n_cmp++;
        if (conflict_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_conflict: got %0d, required 0", conflict_cnt);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got alu=%b mem=%b, required 1/1", alu_ready, mem_ready);
        end
    endtask

    task automatic test_single();
        alu_valid = 1'b1; alu_tag = TAG_W'(3); alu_data = 32'h11;
        exp_q.push_back(res_t'{tag: TAG_W'(3), data: 32'h11});
        step();
        idle_inputs();
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_no_bypass: got valid %b, required 0", cdb_valid);
        end
        step();
        n_cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== TAG_W'(3) || cdb_data !== 32'h11) begin
            n_err++;
            $display("FAIL single_bcast: got v=%b t=%0d d=%h, required 1/3/11", cdb_valid, cdb_tag, cdb_data);
        end
        step();
        n_cmp++;
        if (cdb_valid !== 1'b0 || cdb_tag !== '0) begin
            n_err++;
            $display("FAIL single_idle: got v=%b t=%0d, required 0/0", cdb_valid, cdb_tag);
        end
    endtask

    // Two contended pushes: the first goes to MEM (fresh pointer), the second
    // to ALU because MEM won the previous contended grant.
    task automatic test_conflict();
        logic [TAG_W-1:0]  a_t, m_t, first_t, second_t;
        logic [DATA_W-1:0] a_d, m_d;
        for (int k = 0; k < 2; k++) begin
            a_t = (k == 0) ? TAG_W'(1) : TAG_W'(4);
            m_t = (k == 0) ? TAG_W'(2) : TAG_W'(5);
            a_d = 32'hA000_0000 | DATA_W'(k);
            m_d = 32'hB000_0000 | DATA_W'(k);
            alu_valid = 1'b1; alu_tag = a_t; alu_data = a_d;
            mem_valid = 1'b1; mem_tag = m_t; mem_data = m_d;
            if (k == 0) begin
                exp_q.push_back(res_t'{tag: m_t, data: m_d});
                exp_q.push_back(res_t'{tag: a_t, data: a_d});
                first_t = m_t; second_t = a_t;
            end else begin
                exp_q.push_back(res_t'{tag: a_t, data: a_d});
                exp_q.push_back(res_t'{tag: m_t, data: m_d});
                first_t = a_t; second_t = m_t;
            end
            step();
            idle_inputs();
            step();
            exp_conflict++;
            n_cmp++;
            if (cdb_valid !== 1'b1 || cdb_tag !== first_t) begin
                n_err++;
                $display("FAIL conflict%0d_first: got v=%b t=%0d, required 1/%0d", k, cdb_valid, cdb_tag, first_t);
            end
            n_cmp++;
            if (conflict_cnt !== 16'(exp_conflict)) begin
                n_err++;
                $display("FAIL conflict%0d_cnt: got %0d, required %0d", k, conflict_cnt, exp_conflict);
            end
            step();
            n_cmp++;
            if (cdb_valid !== 1'b1 || cdb_tag !== second_t) begin
                n_err++;
                $display("FAIL conflict%0d_second: got v=%b t=%0d, required 1/%0d", k, cdb_valid, cdb_tag, second_t);
            end
            step();
        end
    endtask

    // Pointer is at MEM. Pairs pushed on two consecutive edges interleave
    // M1, A1, M2, A2 with three contended grants.
    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_tag = TAG_W'(1); alu_data = 32'hA1;
        mem_valid = 1'b1; mem_tag = TAG_W'(2); mem_data = 32'hB1;
        step();
        alu_tag = TAG_W'(3); alu_data = 32'hA2;
        mem_tag = TAG_W'(4); mem_data = 32'hB2;
        exp_q.push_back(res_t'{tag: TAG_W'(2), data: 32'hB1});
        exp_q.push_back(res_t'{tag: TAG_W'(1), data: 32'hA1});
        exp_q.push_back(res_t'{tag: TAG_W'(4), data: 32'hB2});
        exp_q.push_back(res_t'{tag: TAG_W'(3), data: 32'hA2});
        step();
        idle_inputs();
        exp_conflict += 3;
        wait_drain("b2b");
        n_cmp++;
        if (conflict_cnt !== 16'(exp_conflict)) begin
            n_err++;
            $display("FAIL b2b_cnt: got %0d, required %0d", conflict_cnt, exp_conflict);
        end
    endtask

    task automatic test_backpressure();
        alu_valid = 1'b1; alu_tag = TAG_W'(5); alu_data = 32'h55;
        exp_q.push_back(res_t'{tag: TAG_W'(5), data: 32'h55});
        step();
        idle_inputs();
        step();
        cdb_stall = 1'b1;
        alu_valid = 1'b1; alu_tag = TAG_W'(6); alu_data = 32'h66;
        exp_q.push_back(res_t'{tag: TAG_W'(6), data: 32'h66});
        step();
        alu_tag = TAG_W'(7); alu_data = 32'h77;
        exp_q.push_back(res_t'{tag: TAG_W'(7), data: 32'h77});
        step();
        // Third result offered against a full FIFO: must be refused.
        alu_tag = TAG_W'(1); alu_data = 32'hBAD;
        #1;
        n_cmp++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready: got alu=%b mem=%b, required 0/1", alu_ready, mem_ready);
        end
        repeat (2) step();
        n_cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== TAG_W'(5) || cdb_data !== 32'h55) begin
            n_err++;
            $display("FAIL bp_hold: got v=%b t=%0d d=%h, required 1/5/55", cdb_valid, cdb_tag, cdb_data);
        end
        // Release with the offer still up: the pop in this cycle must not
        // open a slot for it.
        cdb_stall = 1'b0;
        step();
        idle_inputs();
        n_cmp++;
        if (cdb_tag !== TAG_W'(6)) begin
            n_err++;
            $display("FAIL bp_release: got tag %0d, required 6", cdb_tag);
        end
        wait_drain("bp");
    endtask

    task automatic test_flush();
        alu_valid = 1'b1; alu_tag = TAG_W'(7); alu_data = 32'h77;
        exp_q.push_back(res_t'{tag: TAG_W'(7), data: 32'h77});
        step();
        idle_inputs();
        step();
        cdb_stall = 1'b1;
        alu_valid = 1'b1; alu_tag = TAG_W'(1); alu_data = 32'h1;
        mem_valid = 1'b1; mem_tag = TAG_W'(2); mem_data = 32'h2;
        step();
        alu_valid = 1'b0;
        mem_tag = TAG_W'(4); mem_data = 32'h4;
        step();
        mem_valid = 1'b0;
        n_cmp++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_prefill: got alu=%b mem=%b, required 1/0", alu_ready, mem_ready);
        end
        flush = 1'b1;
        alu_valid = 1'b1; alu_tag = TAG_W'(5); alu_data = 32'hF5;
        step();
        flush = 1'b0; cdb_stall = 1'b0;
        idle_inputs();
        exp_q.delete();
        n_cmp++;
        if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0) begin
            n_err++;
            $display("FAIL flush_cdb: got v=%b t=%0d d=%h, required 0/0/0", cdb_valid, cdb_tag, cdb_data);
        end
        n_cmp++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready: got alu=%b mem=%b, required 1/1", alu_ready, mem_ready);
        end
        n_cmp++;
        if (conflict_cnt !== 16'(exp_conflict)) begin
            n_err++;
            $display("FAIL flush_cnt_hold: got %0d, required %0d", conflict_cnt, exp_conflict);
        end
        repeat (5) step();
        // Pointer was left at ALU before the flush; flush returns it to MEM.
        alu_valid = 1'b1; alu_tag = TAG_W'(3); alu_data = 32'hC3;
        mem_valid = 1'b1; mem_tag = TAG_W'(6); mem_data = 32'hC6;
        exp_q.push_back(res_t'{tag: TAG_W'(6), data: 32'hC6});
        exp_q.push_back(res_t'{tag: TAG_W'(3), data: 32'hC3});
        step();
        idle_inputs();
        exp_conflict++;
        wait_drain("flush");
        n_cmp++;
        if (conflict_cnt !== 16'(exp_conflict)) begin
            n_err++;
            $display("FAIL flush_post_cnt: got %0d, required %0d", conflict_cnt, exp_conflict);
        end
    endtask

    task automatic test_tag0_reset();
        alu_valid = 1'b1; alu_tag = '0; alu_data = 32'hDEAD;
        mem_valid = 1'b1; mem_tag = '0; mem_data = 32'hBEEF;
        repeat (3) step();
        idle_inputs();
        step();
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL tag0_drop: got valid %b, required 0", cdb_valid);
        end
        // Results buffered mid-stream are discarded by the reset below.
        alu_valid = 1'b1; alu_tag = TAG_W'(1); alu_data = 32'hE1;
        mem_valid = 1'b1; mem_tag = TAG_W'(2); mem_data = 32'hE2;
        step();
        mem_valid = 1'b0;
        alu_tag = TAG_W'(3); alu_data = 32'hE3;
        step();
        rst = 1'b0; flush = 1'b1; cdb_stall = 1'b1;
        mem_valid = 1'b1; mem_tag = TAG_W'(5); mem_data = 32'hE5;
        step();
        exp_conflict = 0;
        n_cmp++;
        if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || conflict_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL midrst_out: got v=%b t=%0d d=%h cnt=%0d, required 0/0/0/0",
                     cdb_valid, cdb_tag, cdb_data, conflict_cnt);
        end
        step();
        n_cmp++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_ready: got alu=%b mem=%b, required 0/0", alu_ready, mem_ready);
        end
        // First push lands on the very first edge with rst high.
        rst = 1'b1; flush = 1'b0; cdb_stall = 1'b0;
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_tag = TAG_W'(6); alu_data = 32'h66;
        exp_q.push_back(res_t'{tag: TAG_W'(6), data: 32'h66});
        step();
        idle_inputs();
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rel_latency: got valid %b, required 0", cdb_valid);
        end
        step();
        n_cmp++;
        if (cdb_valid !== 1'b1 || cdb_tag !== TAG_W'(6)) begin
            n_err++;
            $display("FAIL rel_first_push: got v=%b t=%0d, required 1/6", cdb_valid, cdb_tag);
        end
        wait_drain("rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_tag0_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, result data width.
REQ-002 Parameter TAG_W, default 3, reorder/destination tag width; tag 0 means "no result".
REQ-003 Parameter DEPTH, default 2, entries per source FIFO (power of two, >=2).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-low (reset when rst=0).
REQ-006 flush  input  1  pipeline flush (mispredict); synchronous, active-high.
REQ-007 alu_valid  input  1  ALU result offered this cycle.
REQ-008 alu_tag  input  TAG_W  ALU result destination tag.
REQ-009 alu_data  input  DATA_W  ALU result value.
REQ-010 alu_ready  output  1  ALU FIFO can accept a result this cycle.
REQ-011 mem_valid / mem_tag / mem_data  input  1 / TAG_W / DATA_W  memory-unit result, same meaning as ALU inputs.
REQ-012 mem_ready  output  1  memory FIFO can accept a result this cycle.
REQ-013 cdb_stall  input  1  consumers (RS/ROB) did not take the current broadcast; hold it.
REQ-014 cdb_valid  output  1  broadcast valid, registered.
REQ-015 cdb_tag  output  TAG_W  broadcast tag, registered; 0 whenever cdb_valid=0.
REQ-016 cdb_data  output  DATA_W  broadcast value, registered; 0 whenever cdb_valid=0.
REQ-017 conflict_cnt  output  16  saturating count of cycles in which both FIFOs were non-empty and a grant occurred.

Function
REQ-018 Per source: DEPTH-entry FIFO, FIFO order preserved, with an occupancy count of 0..DEPTH.
REQ-019 x_ready = 1 iff rst=1 and count_x < DEPTH; combinational from current count only, not from a same-cycle pop.
REQ-020 Push on posedge when x_valid=1, x_ready=1, x_tag!=0, and flush=0; x_valid with tag 0 is silently dropped.
REQ-021 Grant step at each posedge with rst=1, flush=0, cdb_stall=0: select one non-empty FIFO head, pop it, and load cdb_valid=1, cdb_tag, cdb_data from it.
REQ-022 Only one FIFO non-empty: grant that one.
REQ-023 Both FIFOs non-empty: grant the source not granted on the most recent grant; the priority pointer starts at MEM after reset/flush and toggles only on a both-non-empty grant.
REQ-024 Both FIFOs empty, no stall: load cdb_valid=0, cdb_tag=0, cdb_data=0.
REQ-025 cdb_stall=1: cdb outputs, FIFO heads and pointer hold; pushes still proceed while ready.
REQ-026 No bypass: a result pushed at edge N appears on cdb at the earliest after edge N+1 (1-cycle minimum latency).
REQ-027 Same-cycle push and pop on one FIFO: count unchanged, data order preserved.
REQ-028 Full FIFO: ready=0 even if a pop occurs the same cycle; no overwrite.
REQ-029 flush=1: at the posedge, empty both FIFOs, clear cdb outputs to 0, and reset the pointer to MEM; a same-cycle push is dropped and the stall is ignored; conflict_cnt holds.
REQ-030 conflict_cnt increments by 1 on a REQ-023 grant and saturates at 16'hFFFF.
REQ-031 Each pushed tag is broadcast exactly once unless flushed or reset.

Reset
REQ-032 rst=0 at a posedge: FIFOs empty, pointer=MEM, cdb_valid=0, cdb_tag=0, cdb_data=0, conflict_cnt=0.
REQ-033 While rst=0: alu_ready=0 and mem_ready=0; no push or grant.
REQ-034 rst overrides flush and cdb_stall; reset mid-transfer discards all buffered results.
REQ-035 First push is possible at the first posedge with rst=1.

Verification
REQ-036 Single ALU result: alu tag 3, data 0x11 at edge 1 -> cdb_valid=1, tag 3, data 0x11 after edge 2; valid=0, tag=0 after edge 3.
REQ-037 Conflict: ALU tag 1 and MEM tag 2 pushed at the same edge -> tag 2 (MEM) on the next edge, tag 1 on the following edge; conflict_cnt=1.
REQ-038 Backpressure: stall=1 with 2 ALU results pushed, third offered -> alu_ready=0 and cdb holds its value; releasing stall drains tags in push order.
REQ-039 Flush: both FIFOs holding entries, flush=1 with a simultaneous push -> next cycle cdb_valid=0, both ready=1, the pushed result is never broadcast.
REQ-040 Tag 0 and reset: alu_valid with tag 0 -> no broadcast; rst=0 mid-stream -> all outputs 0, ready=0 until rst=1.
